div_unit: RTL and testbench

//  Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU.
//  EX initiates with start_i; the divider responds with ready_o and {remainder, quotient}.
//  EX writes the result to HI/LO: HI = remainder, LO = quotient.
//  EX stalls the pipeline through ctrl while start_i=1 and ready_o=0.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit.sv | 115 +++++++++++
 tb/tb_div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared divider definitions: FSM state encodings and handshake constants used by EX and div_unit.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up on completion.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(DATA_W - 1);

  div_state_e          state_q;
  logic [CntW-1:0]     cnt_q;
  logic [DATA_W-1:0]   dvd_q;      // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   dsr_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [2*DATA_W-1:0] res_q;

  logic [DATA_W:0]     trial_diff;
  logic                q_bit;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quo_nxt;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   quo_fix;

  // The shifted remainder is always below 2*divisor, so bit DATA_W is the borrow.
  assign trial_diff = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dsr_q};

  always_comb begin
    q_bit   = ~trial_diff[DATA_W];
    rem_nxt = q_bit ? trial_diff[DATA_W-1:0] : {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
    quo_nxt = {dvd_q[DATA_W-2:0], q_bit};
    quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
    rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q   <= DivOn;
              cnt_q     <= '0;
              rem_q     <= '0;
              dvd_q     <= (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
              dsr_q     <= (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
              neg_quo_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem_q <= signed_div_i && opdata1_i[DATA_W-1];
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            res_q   <= '0;
            state_q <= DivEnd;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            rem_q <= rem_nxt;
            dvd_q <= quo_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastIter) begin
              res_q   <= {rem_fix, quo_fix};
              state_q <= DivEnd;
            end
          end
        end
        DivEnd: begin
          if (start_i == DivStart) begin
            result_o <= res_q;
            ready_o  <= DivResultReady;
          end else begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            state_q  <= DivFree;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, annul, hold/release and async reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts a division and waits for ready_o; operands are scrambled after the sampling edge.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = 0;
    while (!ready_o && lat < 60) begin
      @(posedge clk);
      lat++;
      if (lat == 1) begin
        #1;
        opdata1_i    = ~a;
        opdata2_i    = 32'h0000_0001;
        signed_div_i = ~sgn;
      end
      @(negedge clk);
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_res"}, result_o, exp);
  endtask

  task automatic release_div(input string tag);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_rdy_clr"}, 64'(ready_o), 64'd0);
    check_eq({tag, "_res_clr"}, result_o, {ZeroWord, ZeroWord});
  endtask

  initial begin
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    check_eq("reset_rdy", 64'(ready_o), 64'd0);
    check_eq("reset_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_div("divu_17_3", 1'b0, 32'h11, 32'h3, {32'h2, 32'h5}, 34);
    release_div("divu_17_3");
    run_div("div_m5_6", 1'b1, 32'hFFFF_FFFB, 32'h6, {32'hFFFF_FFFB, 32'h0}, 34);
    release_div("div_m5_6");
    run_div("div_m5_2", 1'b1, 32'hFFFF_FFFB, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 34);
    release_div("div_m5_2");
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34);
    release_div("div_min_m1");
    run_div("divu_by0", 1'b0, 32'h5, 32'h0, 64'd0, 3);
    release_div("divu_by0");
    run_div("divu_small", 1'b0, 32'h3, 32'h11, {32'h3, 32'h0}, 34);
    release_div("divu_small");
    run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34);
    release_div("div_7_m2");

    // Annul mid-division with start held: a fresh start must take the full latency.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    check_eq("annul_rdy", 64'(ready_o), 64'd0);
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("hold%0d_rdy", i), 64'(ready_o), 64'd1);
      check_eq($sformatf("hold%0d_res", i), result_o, {32'h2, 32'hE});
    end
    release_div("hold");
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34);

    // Asynchronous reset while the result is being presented.
    #2 rst = 1'b0;
    #1;
    check_eq("arst_end_rdy", 64'(ready_o), 64'd0);
    check_eq("arst_end_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of an iteration run.
    signed_div_i = 1'b0;
    opdata1_i    = 32'h1234_5678;
    opdata2_i    = 32'h0000_0003;
    start_i      = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_on_rdy", 64'(ready_o), 64'd0);
    check_eq("arst_on_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_div("divu_after_rst", 1'b0, 32'hFFFF_0000, 32'h10, {32'h0, 32'h0FFF_F000}, 34);
    release_div("divu_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
